// File: rtl/mem_miss_ctrl.sv
// ============================================================================
// Module   : mem_miss_ctrl
// Purpose  : Arbitrates I-cache and D-cache misses onto one unified memory
//            port. Dirty victims are written back before the D fill. A wait
//            timeout drops the controller into a sticky error state.
// Options  : MISS_CNT_EN adds saturating miss/writeback event counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_miss_ctrl #(
  parameter int ADDR_W   = 14,
  parameter int LINE_W   = 64,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_hit,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_hit,
  input  logic              d_dirty,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] d_victim_addr,
  input  logic              mem_rdy,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              i_fill,
  output logic              d_fill,
  output logic              stall,
`ifdef MISS_CNT_EN
  output logic [15:0]       i_miss_cnt,
  output logic [15:0]       d_miss_cnt,
  output logic [15:0]       wb_cnt,
`endif
  output logic              timeout
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  // The line datapath lives in the caches; the width is only sanity-checked.
  if ((LINE_W % 16) != 0) begin : g_line_w_chk
    $error("LINE_W must be a multiple of 16");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WB    = 3'd1,
    S_DFILL = 3'd2,
    S_IFILL = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              d_miss, i_miss;

  assign d_miss = d_req & ~d_hit;
  assign i_miss = ~i_hit;

  // Next-state, wait counter and captured request address.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        // D misses win; a simultaneous I miss is re-seen after the D fill.
        if (d_miss && d_dirty) begin
          state_d = S_WB;
          addr_d  = d_victim_addr;
          wait_d  = '0;
        end else if (d_miss) begin
          state_d = S_DFILL;
          addr_d  = d_addr;
          wait_d  = '0;
        end else if (i_miss) begin
          state_d = S_IFILL;
          addr_d  = i_addr;
          wait_d  = '0;
        end
      end
      S_WB, S_DFILL, S_IFILL: begin
        if (mem_rdy) begin
          wait_d = '0;
          if (state_q == S_WB) begin
            state_d = S_DFILL;
            addr_d  = d_addr;
          end else begin
            // Always pass through IDLE so the fresh fill is seen as a hit.
            state_d = S_IDLE;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
    end
  end

  assign mem_we   = (state_q == S_WB);
  assign mem_re   = (state_q == S_DFILL) || (state_q == S_IFILL);
  assign mem_addr = addr_q;
  // A reset in the completion cycle abandons the fill.
  assign d_fill   = (state_q == S_DFILL) && mem_rdy && !rst;
  assign i_fill   = (state_q == S_IFILL) && mem_rdy && !rst;
  assign timeout  = (state_q == S_ERR);
  assign stall    = (state_q != S_IDLE) || d_miss || i_miss;

`ifdef MISS_CNT_EN
  logic [15:0] i_miss_cnt_q, i_miss_cnt_d;
  logic [15:0] d_miss_cnt_q, d_miss_cnt_d;
  logic [15:0] wb_cnt_q, wb_cnt_d;

  // Count state entries, saturating at all-ones.
  always_comb begin
    i_miss_cnt_d = i_miss_cnt_q;
    d_miss_cnt_d = d_miss_cnt_q;
    wb_cnt_d     = wb_cnt_q;
    if (state_d == S_IFILL && state_q != S_IFILL && i_miss_cnt_q != 16'hFFFF)
      i_miss_cnt_d = i_miss_cnt_q + 16'd1;
    if (state_d == S_DFILL && state_q != S_DFILL && d_miss_cnt_q != 16'hFFFF)
      d_miss_cnt_d = d_miss_cnt_q + 16'd1;
    if (state_d == S_WB && state_q != S_WB && wb_cnt_q != 16'hFFFF)
      wb_cnt_d = wb_cnt_q + 16'd1;
  end

  // Event counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_miss_cnt_q <= '0;
      d_miss_cnt_q <= '0;
      wb_cnt_q     <= '0;
    end else begin
      i_miss_cnt_q <= i_miss_cnt_d;
      d_miss_cnt_q <= d_miss_cnt_d;
      wb_cnt_q     <= wb_cnt_d;
    end
  end

  assign i_miss_cnt = i_miss_cnt_q;
  assign d_miss_cnt = d_miss_cnt_q;
  assign wb_cnt     = wb_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_miss_ctrl.sv
// ============================================================================
// Module   : tb_mem_miss_ctrl
// Purpose  : Directed bench for mem_miss_ctrl with a queue-based reference
//            model of memory operations; MISS_CNT_EN also checks counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_miss_ctrl;

  localparam int AW   = 14;
  localparam int MAXW = 8;

  logic          clk = 1'b0;
  logic          rst, i_hit, d_req, d_hit, d_dirty, mem_rdy;
  logic [AW-1:0] i_addr, d_addr, d_victim_addr;
  logic          mem_re, mem_we, i_fill, d_fill, stall, timeout;
  logic [AW-1:0] mem_addr;
`ifdef MISS_CNT_EN
  logic [15:0]   i_miss_cnt, d_miss_cnt, wb_cnt;
`endif

  always #5 clk = ~clk;

  mem_miss_ctrl #(.ADDR_W(AW), .LINE_W(64), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .i_hit(i_hit), .i_addr(i_addr),
    .d_req(d_req), .d_hit(d_hit), .d_dirty(d_dirty), .d_addr(d_addr),
    .d_victim_addr(d_victim_addr), .mem_rdy(mem_rdy),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .i_fill(i_fill), .d_fill(d_fill), .stall(stall),
`ifdef MISS_CNT_EN
    .i_miss_cnt(i_miss_cnt), .d_miss_cnt(d_miss_cnt), .wb_cnt(wb_cnt),
`endif
    .timeout(timeout)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of pending memory operations
  // kind 0 = write back victim, 1 = D read, 2 = I read
  typedef struct {
    int            kind;
    logic [AW-1:0] addr;
  } op_t;

  op_t   q[$];
  bit    m_valid = 0;
  bit    m_err   = 0;
  int    m_wait  = 0;
  logic [15:0] m_icnt = 0, m_dcnt = 0, m_wcnt = 0;

  task automatic push_op(input int k, input logic [AW-1:0] a);
    op_t o;
    o.kind = k;
    o.addr = a;
    q.push_back(o);
  endtask

  // An operation starts when it reaches the head of the queue.
  task automatic head_started();
    m_wait = 0;
    if (q.size() != 0) begin
      if (q[0].kind == 0 && m_wcnt != 16'hFFFF) m_wcnt++;
      if (q[0].kind == 1 && m_dcnt != 16'hFFFF) m_dcnt++;
      if (q[0].kind == 2 && m_icnt != 16'hFFFF) m_icnt++;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_valid = 1;
      m_err   = 0;
      m_wait  = 0;
      m_icnt  = 0;
      m_dcnt  = 0;
      m_wcnt  = 0;
    end else if (m_valid && !m_err) begin
      if (q.size() == 0) begin
        if (d_req && !d_hit) begin
          if (d_dirty) push_op(0, d_victim_addr);
          push_op(1, d_addr);
        end else if (!i_hit) begin
          push_op(2, i_addr);
        end
        if (q.size() != 0) head_started();
      end else if (mem_rdy) begin
        void'(q.pop_front());
        if (q.size() != 0) head_started();
      end else begin
        m_wait++;
        if (m_wait == MAXW) begin
          m_err = 1;
          q.delete();
        end
      end
    end
  end

  // Compare every DUT output against the model once reset has been seen.
  always @(negedge clk) begin
    if (m_valid) begin
      bit busy;
      int k;
      busy = !m_err && (q.size() != 0);
      k    = busy ? q[0].kind : -1;
      chk("mem_we", mem_we, busy && k == 0);
      chk("mem_re", mem_re, busy && k != 0);
      if (busy) chk("mem_addr", mem_addr, q[0].addr);
      chk("d_fill", d_fill, busy && k == 1 && mem_rdy && !rst);
      chk("i_fill", i_fill, busy && k == 2 && mem_rdy && !rst);
      chk("timeout", timeout, m_err);
      chk("stall", stall, m_err || busy || (d_req && !d_hit) || !i_hit);
`ifdef MISS_CNT_EN
      chk("i_miss_cnt", i_miss_cnt, m_icnt);
      chk("d_miss_cnt", d_miss_cnt, m_dcnt);
      chk("wb_cnt", wb_cnt, m_wcnt);
`endif
    end
  end

  // ---------------- directed stimulus with literal expectations
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic nck();
    @(negedge clk);
  endtask

  initial begin
    rst = 1; i_hit = 1; d_req = 0; d_hit = 1; d_dirty = 0; mem_rdy = 0;
    i_addr = '0; d_addr = '0; d_victim_addr = '0;
    cyc(); cyc();
    nck();
    chk("rst_re", mem_re, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_fill", {i_fill, d_fill}, 0);
    rst = 0;
    cyc();

    // I miss at 0123, memory ready on the 4th request cycle
    i_hit = 0; i_addr = 14'h0123;
    nck(); chk("imiss_stall", stall, 1); chk("imiss_idle_re", mem_re, 0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      mem_rdy = (k == 3);
      nck();
      chk("ifill_re", mem_re, 1);
      chk("ifill_addr", mem_addr, 14'h0123);
      chk("ifill_pulse", i_fill, k == 3);
      cyc();
    end
    i_hit = 1; mem_rdy = 0;
    nck(); chk("ifill_after_stall", stall, 0); chk("ifill_after_re", mem_re, 0);
    cyc();

    // Dirty D miss: write back 0040, then read 0080
    d_req = 1; d_hit = 0; d_dirty = 1; d_victim_addr = 14'h0040; d_addr = 14'h0080;
    nck(); chk("dmiss_stall", stall, 1);
    cyc();
    for (int k = 0; k < 2; k++) begin
      mem_rdy = (k == 1);
      nck();
      chk("wb_we", mem_we, 1); chk("wb_re", mem_re, 0);
      chk("wb_addr", mem_addr, 14'h0040);
      cyc();
    end
    for (int k = 0; k < 3; k++) begin
      mem_rdy = (k == 2);
      nck();
      chk("dfill_re", mem_re, 1); chk("dfill_we", mem_we, 0);
      chk("dfill_addr", mem_addr, 14'h0080);
      chk("dfill_pulse", d_fill, k == 2);
      cyc();
    end
    d_hit = 1; d_dirty = 0; mem_rdy = 0;
    nck(); chk("dfill_after_stall", stall, 0); chk("dfill_after_re", mem_re, 0);
    cyc();
    d_req = 0;

    // Simultaneous clean D and I misses: D first, one IDLE cycle, then I
    d_req = 1; d_hit = 0; i_hit = 0; d_addr = 14'h0200; i_addr = 14'h0300;
    cyc();
    for (int k = 0; k < 2; k++) begin
      mem_rdy = (k == 1);
      nck();
      chk("both_d_addr", mem_addr, 14'h0200);
      chk("both_d_pulse", d_fill, k == 1);
      chk("both_d_ifill", i_fill, 0);
      cyc();
    end
    d_hit = 1; mem_rdy = 0;
    nck(); chk("both_gap_stall", stall, 1); chk("both_gap_re", mem_re, 0);
    cyc();
    for (int k = 0; k < 2; k++) begin
      mem_rdy = (k == 1);
      nck();
      chk("both_i_addr", mem_addr, 14'h0300);
      chk("both_i_pulse", i_fill, k == 1);
      cyc();
    end
    i_hit = 1; d_req = 0; mem_rdy = 0;
    nck(); chk("both_done_stall", stall, 0);
    cyc();

    // mem_rdy while idle is ignored
    mem_rdy = 1;
    nck(); chk("idle_rdy_fill", {i_fill, d_fill}, 0); chk("idle_rdy_re", mem_re, 0);
    cyc();
    mem_rdy = 0;
    cyc();

    // Reset during a DFILL wait, with mem_rdy arriving in the reset cycle
    d_req = 1; d_hit = 0; d_addr = 14'h0111;
    cyc(); cyc();
    rst = 1; mem_rdy = 1;
    nck(); chk("rstmid_dfill", d_fill, 0); chk("rstmid_re_before", mem_re, 1);
    cyc();
    rst = 0; mem_rdy = 0; d_req = 0; d_hit = 1;
    nck(); chk("rstmid_re_after", mem_re, 0); chk("rstmid_stall", stall, 0);
    chk("rstmid_addr", mem_addr, 0);
    cyc();

    // Memory never answers: timeout after MAXW wait cycles
    i_hit = 0; i_addr = 14'h0055;
    cyc();
    for (int k = 0; k < MAXW; k++) begin
      nck(); chk("to_wait_re", mem_re, 1); chk("to_wait_flag", timeout, 0);
      cyc();
    end
    nck();
    chk("to_flag", timeout, 1);
    chk("to_strobes", {mem_re, mem_we}, 0);
    chk("to_stall", stall, 1);
    mem_rdy = 1; i_hit = 1;
    cyc();
    nck(); chk("to_sticky", timeout, 1); chk("to_sticky_stall", stall, 1);
    chk("to_no_fill", i_fill, 0);
    mem_rdy = 0;
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    nck(); chk("to_cleared", timeout, 0);
    cyc();

    // Three I misses and two dirty D misses, each answered immediately
    for (int n = 0; n < 3; n++) begin
      i_hit = 0; i_addr = AW'(14'h0400 + n);
      cyc();
      mem_rdy = 1;
      cyc();
      i_hit = 1; mem_rdy = 0;
      cyc();
    end
    for (int n = 0; n < 2; n++) begin
      d_req = 1; d_hit = 0; d_dirty = 1;
      d_victim_addr = AW'(14'h0500 + n); d_addr = AW'(14'h0600 + n);
      cyc();
      mem_rdy = 1;
      cyc(); cyc();
      d_req = 0; d_hit = 1; d_dirty = 0; mem_rdy = 0;
      cyc();
    end
    nck();
    chk("cnt_phase_idle", stall, 0);
`ifdef MISS_CNT_EN
    chk("i_miss_cnt_lit", i_miss_cnt, 3);
    chk("d_miss_cnt_lit", d_miss_cnt, 2);
    chk("wb_cnt_lit", wb_cnt, 2);
`endif
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
